// File: rtl/alu_fwd_add_or_unit.sv
// alu_fwd_add_or_unit
// Registered FORWARD / ADD / OR slice of the processor datapath.
// One-cycle latency; OUT_VALID pulses once per accepted request and
// ILLEGAL flags any SELECT outside {000, 001, 011}.
// Optional macro ALU_FLAGS_EN adds registered ZERO and CARRY outputs.
module alu_fwd_add_or_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    output logic [WIDTH-1:0] RESULT,
    output logic             OUT_VALID,
    output logic             ILLEGAL
`ifdef ALU_FLAGS_EN
    ,
    output logic             ZERO,
    output logic             CARRY
`endif
);

    localparam logic [2:0] SEL_FWD = 3'b000;
    localparam logic [2:0] SEL_ADD = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b011;

    // Decode helper: true for the codes this slice implements.
    function automatic logic is_supported(input logic [2:0] sel);
        return (sel == SEL_FWD) || (sel == SEL_ADD) || (sel == SEL_OR);
    endfunction

    // ---- stage p0: all three results computed in parallel, SELECT muxes ----
    logic [WIDTH-1:0] fwd_p0;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] or_p0;
    logic [WIDTH-1:0] res_p0;
    logic             illegal_p0;
    logic             vld_p0;
`ifdef ALU_FLAGS_EN
    logic             carry_add_p0;
    logic             carry_p0;
`endif

    assign fwd_p0 = DATA2;
    assign or_p0  = DATA1 | DATA2;
    assign vld_p0 = IN_VALID;
`ifdef ALU_FLAGS_EN
    assign {carry_add_p0, sum_p0} = {1'b0, DATA1} + {1'b0, DATA2};
`else
    assign sum_p0 = DATA1 + DATA2;
`endif

    // Result select; reserved codes return zero and raise the illegal flag.
    always_comb begin
        res_p0     = '0;
        illegal_p0 = 1'b0;
`ifdef ALU_FLAGS_EN
        carry_p0   = 1'b0;
`endif
        case (SELECT)
            SEL_FWD: res_p0 = fwd_p0;
            SEL_ADD: begin
                res_p0 = sum_p0;
`ifdef ALU_FLAGS_EN
                carry_p0 = carry_add_p0;
`endif
            end
            SEL_OR:  res_p0 = or_p0;
            default: illegal_p0 = !is_supported(SELECT);
        endcase
    end

    // ---- stage p1: registered outputs ----
    logic [WIDTH-1:0] res_p1;
    logic             illegal_p1;
    logic             vld_p1;

    // Valid and illegal are one-cycle pulses per accepted request.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            vld_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            vld_p1     <= vld_p0;
            illegal_p1 <= vld_p0 & illegal_p0;
        end
    end

    // Result loads on accept and holds across idle cycles.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            res_p1 <= '0;
        end else if (vld_p0) begin
            res_p1 <= res_p0;
        end
    end

    assign RESULT    = res_p1;
    assign OUT_VALID = vld_p1;
    assign ILLEGAL   = illegal_p1;

`ifdef ALU_FLAGS_EN
    logic zero_p1;
    logic carry_p1;

    // Flags follow the loaded result and hold on idle cycles.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
        end else if (vld_p0) begin
            zero_p1  <= (res_p0 == '0);
            carry_p1 <= carry_p0;
        end
    end

    assign ZERO  = zero_p1;
    assign CARRY = carry_p1;
`endif

endmodule

// File: tb/tb_alu_fwd_add_or_unit.sv
// Directed testbench for alu_fwd_add_or_unit (WIDTH = 8).
module tb_alu_fwd_add_or_unit;

    logic       CLK;
    logic       RESETN;
    logic       IN_VALID;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic [7:0] RESULT;
    logic       OUT_VALID;
    logic       ILLEGAL;
`ifdef ALU_FLAGS_EN
    logic       ZERO;
    logic       CARRY;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_fwd_add_or_unit #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .IN_VALID  (IN_VALID),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .SELECT    (SELECT),
        .RESULT    (RESULT),
        .OUT_VALID (OUT_VALID),
        .ILLEGAL   (ILLEGAL)
`ifdef ALU_FLAGS_EN
        ,
        .ZERO      (ZERO),
        .CARRY     (CARRY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one request, let one rising edge pass, then settle 1 time unit.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s);
        IN_VALID = v;
        DATA1    = a;
        DATA2    = b;
        SELECT   = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        // Power-on reset values
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_init got res=%h vld=%b ill=%b exp res=00 vld=0 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
        // Load a non-zero result, then assert reset between edges
        drive(1'b1, 8'h00, 8'h5A, 3'b000);
        total_cnt++;
        if (RESULT !== 8'h5A || OUT_VALID !== 1'b1)
            $display("FAIL reset_preload got res=%h vld=%b exp res=5a vld=1", RESULT, OUT_VALID);
        else pass_cnt++;
        #2;
        RESETN = 1'b0;
        #1;
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_async got res=%h vld=%b ill=%b exp res=00 vld=0 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
        // A request sampled while reset is held is lost
        IN_VALID = 1'b1;
        DATA1    = 8'h11;
        DATA2    = 8'h22;
        SELECT   = 3'b001;
        @(posedge CLK);
        #1;
        RESETN   = 1'b1;
        IN_VALID = 1'b0;
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_lost_req got res=%h vld=%b ill=%b exp res=00 vld=0 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
        // No pulse after release without a new accept
        drive(1'b0, 8'h11, 8'h22, 3'b001);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_release got res=%h vld=%b ill=%b exp res=00 vld=0 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
    endtask

    task automatic test_forward;
        drive(1'b1, 8'h55, 8'hA3, 3'b000);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'hA3, 1'b1, 1'b0})
            $display("FAIL forward got res=%h vld=%b ill=%b exp res=a3 vld=1 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({ZERO, CARRY} !== 2'b00)
            $display("FAIL forward_flags got z=%b c=%b exp z=0 c=0", ZERO, CARRY);
        else pass_cnt++;
`endif
    endtask

    task automatic test_add;
        drive(1'b1, 8'h05, 8'h03, 3'b001);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h08, 1'b1, 1'b0})
            $display("FAIL add_small got res=%h vld=%b ill=%b exp res=08 vld=1 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
        drive(1'b1, 8'hFF, 8'h01, 3'b001);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL add_wrap got res=%h vld=%b ill=%b exp res=00 vld=1 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({ZERO, CARRY} !== 2'b11)
            $display("FAIL add_wrap_flags got z=%b c=%b exp z=1 c=1", ZERO, CARRY);
        else pass_cnt++;
        // Flags hold on idle
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        total_cnt++;
        if ({ZERO, CARRY} !== 2'b11)
            $display("FAIL flags_hold got z=%b c=%b exp z=1 c=1", ZERO, CARRY);
        else pass_cnt++;
`endif
        drive(1'b1, 8'h80, 8'h7F, 3'b001);
        total_cnt++;
        if (RESULT !== 8'hFF)
            $display("FAIL add_nocarry got res=%h exp res=ff", RESULT);
        else pass_cnt++;
    endtask

    task automatic test_or;
        drive(1'b1, 8'hF0, 8'h0C, 3'b011);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'hFC, 1'b1, 1'b0})
            $display("FAIL or got res=%h vld=%b ill=%b exp res=fc vld=1 ill=0",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
    endtask

    task automatic test_reserved;
        drive(1'b1, 8'hFF, 8'hFF, 3'b010);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL reserved_010 got res=%h vld=%b ill=%b exp res=00 vld=1 ill=1",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({ZERO, CARRY} !== 2'b10)
            $display("FAIL reserved_flags got z=%b c=%b exp z=1 c=0", ZERO, CARRY);
        else pass_cnt++;
`endif
        // Preload non-zero so the reserved zero-load is observable
        drive(1'b1, 8'h00, 8'h3C, 3'b000);
        drive(1'b1, 8'hFF, 8'hFF, 3'b111);
        total_cnt++;
        if ({RESULT, OUT_VALID, ILLEGAL} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL reserved_111 got res=%h vld=%b ill=%b exp res=00 vld=1 ill=1",
                     RESULT, OUT_VALID, ILLEGAL);
        else pass_cnt++;
        drive(1'b1, 8'h01, 8'h02, 3'b100);
        total_cnt++;
        if (ILLEGAL !== 1'b1)
            $display("FAIL reserved_100 got ill=%b exp ill=1", ILLEGAL);
        else pass_cnt++;
        // Illegal is a single-cycle pulse
        drive(1'b0, 8'h01, 8'h02, 3'b100);
        total_cnt++;
        if ({OUT_VALID, ILLEGAL} !== 2'b00)
            $display("FAIL illegal_idle got vld=%b ill=%b exp vld=0 ill=0", OUT_VALID, ILLEGAL);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_res [4];
        logic       exp_vld [4];
        logic       vin     [4];
        logic [7:0] a       [4];
        logic [7:0] b       [4];
        logic [2:0] s       [4];
        vin = '{1'b1, 1'b1, 1'b0, 1'b0};
        a   = '{8'h01, 8'h01, 8'h00, 8'h00};
        b   = '{8'h01, 8'h02, 8'h00, 8'h00};
        s   = '{3'b001, 3'b011, 3'b000, 3'b000};
        exp_res = '{8'h02, 8'h03, 8'h03, 8'h03};
        exp_vld = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(vin[i], a[i], b[i], s[i]);
            total_cnt++;
            if (RESULT !== exp_res[i] || OUT_VALID !== exp_vld[i] || ILLEGAL !== 1'b0)
                $display("FAIL b2b_%0d got res=%h vld=%b ill=%b exp res=%h vld=%b ill=0",
                         i, RESULT, OUT_VALID, ILLEGAL, exp_res[i], exp_vld[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        RESETN   = 1'b0;
        IN_VALID = 1'b0;
        DATA1    = '0;
        DATA2    = '0;
        SELECT   = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        test_reset;
        test_forward;
        test_add;
        test_or;
        test_reserved;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
